t_ff_count_ctrl: RTL and testbench
==================================

Name: t_ff_count_ctrl

Overview:
- Sequencing controller for a bank of WIDTH toggle flip-flops. Each flip-flop has a synchronous active-low clear and samples its toggle input on posedge clk.
- The block computes the per-bit toggle vector from the bank's current state, making the bank count up or down between 0 and a programmable limit.
- It handles bank clear, limit preload, terminal-count detection, one-shot/auto-reload and start/stop/done handshaking.
- It sits beside the toggle-FF bank; the bank's q outputs feed back into q_in.

Parameters:
- WIDTH, 4, number of toggle flip-flops in the controlled bank (legal range 2..16).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  begin a count sequence (sampled only in IDLE)
- stop  input  1  abort the current sequence
- dir  input  1  0 = count up 0→limit, 1 = count down limit→0 (captured at start)
- auto_reload  input  1  1 = restart automatically at terminal count (captured at start)
- limit  input  WIDTH  terminal/preload value (captured at start)
- tick  input  1  count enable / prescaler strobe
- q_in  input  WIDTH  current q outputs of the flip-flop bank
- t_out  output  WIDTH  toggle inputs to the bank (combinational from state regs and q_in)
- bank_rstn  output  1  drives the bank's synchronous active-low clear
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle registered pulse: one-shot sequence completed
- wrap  output  1  one-cycle registered pulse: auto-reload occurred

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; lim_r, dir_r and ar_r are cleared; done=0; wrap=0.
  - t_out=0, busy=0.
  - bank_rstn=0 for as long as rstn is low (combinational), so the bank is also cleared.
- Reset mid-sequence aborts immediately with no done or wrap pulse.
- States: IDLE, CLEAR, PRELOAD, RUN.
- IDLE:
  - t_out=0, bank_rstn=1.
  - start=1 and stop=0: capture limit, dir and auto_reload, then go to CLEAR.
  - start and stop high together: stop wins, stay in IDLE.
- CLEAR (exactly 1 cycle):
  - bank_rstn=0, t_out=0.
  - Next state is PRELOAD if dir_r=1, otherwise RUN.
- PRELOAD (exactly 1 cycle):
  - t_out = q_in ^ lim_r, which loads the limit into the bank.
  - Next state is RUN.
- RUN with tick=0: t_out=0, hold.
- RUN with tick=1, terminal value is lim_r (up) or 0 (down):
  - q_in ≠ terminal, up: t_out[0]=1 and t_out[i] = AND of q_in[i-1:0].
  - q_in ≠ terminal, down: t_out[0]=1 and t_out[i] = NOR of q_in[i-1:0].
  - Binary wrap from all-ones to 0 (up) or 0 to all-ones (down) never occurs, because the terminal is reached first.
  - q_in = terminal, ar_r=1: t_out = q_in ^ reload value (0 for up, lim_r for down); wrap=1 next cycle; stay in RUN.
  - q_in = terminal, ar_r=0: t_out=0; go to IDLE; done=1 next cycle.
- stop=1 in CLEAR, PRELOAD or RUN:
  - Go to IDLE next cycle with t_out=0 that cycle.
  - No done pulse; the bank holds its value.
- start while busy is ignored; limit, dir and auto_reload changes while busy are ignored.
- limit=0: the first RUN tick is terminal (up and down alike).
- Latency with tick held at 1 (start sampled at edge 0):
  - Up: RUN begins in cycle 2 with q=0; q=L in cycle 2+L; done and busy=0 in cycle 3+L.
  - Down: RUN begins in cycle 3 with q=L; q=0 in cycle 3+L; done in cycle 4+L.
- done and wrap are never high at the same time.

Test Plan:
- Reset: rstn=0 with stale bank q=1010 → bank_rstn=0, bank reads 0000 next edge; t_out=0, busy=0, done=0.
- Up one-shot: WIDTH=4, limit=5, dir=0, tick=1 → q steps 0,1,2,3,4,5; done pulses 1 cycle in cycle 8 after start; q holds 5.
- Down auto-reload: limit=3, dir=1 → PRELOAD gives q=3; sequence 3,2,1,0,3,2…; wrap pulses once per reload; done never asserts.
- Tick gating: limit=2, tick high every 3rd cycle → q advances only on tick cycles; done arrives 1 cycle after the tick that sees q=2.
- Stop/start collision:
  - stop mid-RUN at q=4 (limit=9) → IDLE, q holds 4, no done.
  - start and stop together in IDLE → stays IDLE.
  - start while busy → ignored.
- Edge cases:
  - limit=0 up → done in cycle 3.
  - limit=15 up with WIDTH=4 → reaches 15 without wrapping to 0.
  - rstn deasserted mid-RUN → immediate IDLE, bank cleared.

Source files
------------

// File: rtl/t_ff_count_ctrl.sv
// t_ff_count_ctrl: sequences a bank of toggle flip-flops to count up or down
// between 0 and a programmable limit, with clear, preload and auto-reload.
module t_ff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  input  logic             tick,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             bank_rstn,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_PRELOAD = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_lim;
  logic             r_dir;
  logic             r_ar;
  logic             r_done;
  logic             r_wrap;
  logic [WIDTH-1:0] w_cnt_t;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_reload;
  logic             w_hit;
  logic             w_fire;
  logic             w_end;
  logic             w_run;
  // A bit toggles when every lower bit is 1 (up) or 0 (down)
  always_comb begin
    w_cnt_t = '0;
    w_run   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_t[i] = w_run;
      w_run      = w_run & (r_dir ? ~q_in[i] : q_in[i]);
    end
  end
  assign w_term   = r_dir ? '0 : r_lim;
  assign w_reload = r_dir ? r_lim : '0;
  assign w_hit    = (q_in == w_term);
  assign w_fire   = (r_state == S_IDLE) && start && !stop;
  assign w_end    = (r_state == S_RUN) && tick && w_hit && !stop;
  always_comb begin
    t_out = '0;
    if (!stop)
      t_out = (r_state == S_PRELOAD) ? (q_in ^ r_lim) :
              (r_state == S_RUN && tick) ? (w_hit ? (r_ar ? (q_in ^ w_reload) : '0) : w_cnt_t) :
              '0;
  end
  always_comb begin
    w_next = S_IDLE;
    if (r_state != S_IDLE && stop)
      w_next = S_IDLE;
    else
      w_next = (r_state == S_IDLE)    ? (w_fire ? S_CLEAR : S_IDLE) :
               (r_state == S_CLEAR)   ? (r_dir ? S_PRELOAD : S_RUN) :
               (r_state == S_PRELOAD) ? S_RUN :
               (w_end && !r_ar)       ? S_IDLE : S_RUN;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_lim   <= '0;
      r_dir   <= 1'b0;
      r_ar    <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_end & ~r_ar;
      r_wrap  <= w_end & r_ar;
      if (w_fire) begin
        r_lim <= limit;
        r_dir <= dir;
        r_ar  <= auto_reload;
      end
    end
  end
  assign bank_rstn = rstn && (r_state != S_CLEAR);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign wrap      = r_wrap;
endmodule

// File: tb/tb_t_ff_count_ctrl.sv
// tb_t_ff_count_ctrl: directed bench driving the controller against a
// behavioural toggle-FF bank whose q feeds back into q_in.
module tb_t_ff_count_ctrl;
  logic       clk;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       dir;
  logic       auto_reload;
  logic [3:0] limit;
  logic       tick;
  logic [3:0] bank_q = 4'b1010;
  logic [3:0] t_out;
  logic       bank_rstn;
  logic       busy;
  logic       done;
  logic       wrap;
  int passed = 0;
  int total  = 0;

  t_ff_count_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .dir(dir),
    .auto_reload(auto_reload), .limit(limit), .tick(tick), .q_in(bank_q),
    .t_out(t_out), .bank_rstn(bank_rstn), .busy(busy), .done(done), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bank_q <= !bank_rstn ? 4'd0 : (bank_q ^ t_out);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [3:0] l, input logic d, input logic a);
    limit = l; dir = d; auto_reload = a; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bank_rstn !== 1'b0) $display("FAIL reset_bank_rstn: got %0b want 0", bank_rstn); else passed++;
    total++; if (t_out !== 4'd0) $display("FAIL reset_t_out: got %0d want 0", t_out); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) $display("FAIL reset_flags: busy=%0b done=%0b wrap=%0b want 000", busy, done, wrap); else passed++;
    step();
    total++; if (bank_q !== 4'd0) $display("FAIL reset_bank_q: got %0d want 0", bank_q); else passed++;
    rstn = 1'b1;
    step();
    total++; if (bank_rstn !== 1'b1) $display("FAIL idle_bank_rstn: got %0b want 1", bank_rstn); else passed++;
  endtask

  task automatic test_up_oneshot();
    tick = 1'b1;
    kick(4'd5, 1'b0, 1'b0);
    total++; if (busy !== 1'b1 || bank_rstn !== 1'b0) $display("FAIL up_clear: busy=%0b bank_rstn=%0b want 1 0", busy, bank_rstn); else passed++;
    step();
    total++; if (bank_q !== 4'd0) $display("FAIL up_start_q: got %0d want 0", bank_q); else passed++;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (bank_q !== 4'(k) || done !== 1'b0) $display("FAIL up_step%0d: q=%0d done=%0b want %0d 0", k, bank_q, done, k); else passed++;
    end
    step();
    total++; if (done !== 1'b1 || busy !== 1'b0 || bank_q !== 4'd5) $display("FAIL up_done: done=%0b busy=%0b q=%0d want 1 0 5", done, busy, bank_q); else passed++;
    step();
    total++; if (done !== 1'b0 || bank_q !== 4'd5) $display("FAIL up_done_pulse: done=%0b q=%0d want 0 5", done, bank_q); else passed++;
  endtask

  task automatic test_down_reload();
    logic [3:0] eq;
    logic       ew;
    kick(4'd3, 1'b1, 1'b1);
    step();
    total++; if (bank_q !== 4'd0 || t_out !== 4'd3) $display("FAIL dn_preload: q=%0d t=%0d want 0 3", bank_q, t_out); else passed++;
    step();
    total++; if (bank_q !== 4'd3) $display("FAIL dn_loaded: got %0d want 3", bank_q); else passed++;
    for (int i = 0; i < 8; i++) begin
      eq = 4'(3 - ((i + 1) % 4));
      ew = ((i + 1) % 4) == 0;
      step();
      total++; if (bank_q !== eq || wrap !== ew || done !== 1'b0) $display("FAIL dn_seq%0d: q=%0d wrap=%0b done=%0b want %0d %0b 0", i, bank_q, wrap, done, eq, ew); else passed++;
    end
    stop = 1'b1;
    #1;
    total++; if (t_out !== 4'd0) $display("FAIL dn_stop_t: got %0d want 0", t_out); else passed++;
    step();
    stop = 1'b0;
    total++; if (busy !== 1'b0 || bank_q !== 4'd3 || done !== 1'b0) $display("FAIL dn_stop: busy=%0b q=%0d done=%0b want 0 3 0", busy, bank_q, done); else passed++;
  endtask

  task automatic test_tick_gating();
    logic [3:0] eq;
    logic       ed;
    tick = 1'b0;
    kick(4'd2, 1'b0, 1'b0);
    step();
    total++; if (bank_q !== 4'd0 || t_out !== 4'd0) $display("FAIL tg_hold: q=%0d t=%0d want 0 0", bank_q, t_out); else passed++;
    eq = 4'd0;
    for (int c = 0; c < 9; c++) begin
      tick = (c % 3) == 2;
      ed = tick && eq == 4'd2;
      if (tick && eq != 4'd2) eq = eq + 4'd1;
      step();
      total++; if (bank_q !== eq || done !== ed) $display("FAIL tg_c%0d: q=%0d done=%0b want %0d %0b", c, bank_q, done, eq, ed); else passed++;
    end
    tick = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL tg_idle: busy=%0b want 0", busy); else passed++;
    tick = 1'b1;
  endtask

  task automatic test_stop_collision();
    kick(4'd9, 1'b0, 1'b0);
    step();
    repeat (4) step();
    total++; if (bank_q !== 4'd4) $display("FAIL sc_q4: got %0d want 4", bank_q); else passed++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (busy !== 1'b0 || bank_q !== 4'd4 || done !== 1'b0) $display("FAIL sc_stop: busy=%0b q=%0d done=%0b want 0 4 0", busy, bank_q, done); else passed++;
    step();
    total++; if (done !== 1'b0 || bank_q !== 4'd4) $display("FAIL sc_hold: done=%0b q=%0d want 0 4", done, bank_q); else passed++;
    start = 1'b1; stop = 1'b1;
    step();
    total++; if (busy !== 1'b0) $display("FAIL sc_both: busy=%0b want 0", busy); else passed++;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    kick(4'd3, 1'b0, 1'b0);
    start = 1'b1; limit = 4'd9; dir = 1'b1; auto_reload = 1'b1;
    step();
    step();
    total++; if (bank_q !== 4'd1) $display("FAIL bb_ignore: q=%0d want 1", bank_q); else passed++;
    step();
    step();
    total++; if (bank_q !== 4'd3 || busy !== 1'b1) $display("FAIL bb_q3: q=%0d busy=%0b want 3 1", bank_q, busy); else passed++;
    step();
    total++; if (done !== 1'b1 || busy !== 1'b0 || wrap !== 1'b0) $display("FAIL bb_done: done=%0b busy=%0b wrap=%0b want 1 0 0", done, busy, wrap); else passed++;
    start = 1'b0;
  endtask

  task automatic test_edges();
    kick(4'd0, 1'b0, 1'b0);
    step();
    total++; if (bank_q !== 4'd0 || done !== 1'b0) $display("FAIL l0_c2: q=%0d done=%0b want 0 0", bank_q, done); else passed++;
    step();
    total++; if (done !== 1'b1 || bank_q !== 4'd0) $display("FAIL l0_done: done=%0b q=%0d want 1 0", done, bank_q); else passed++;
    kick(4'd15, 1'b0, 1'b0);
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      total++; if (bank_q !== 4'(k)) $display("FAIL l15_step%0d: q=%0d want %0d", k, bank_q, k); else passed++;
    end
    step();
    total++; if (done !== 1'b1 || bank_q !== 4'd15) $display("FAIL l15_done: done=%0b q=%0d want 1 15", done, bank_q); else passed++;
    kick(4'd9, 1'b0, 1'b0);
    repeat (4) step();
    total++; if (bank_q !== 4'd3) $display("FAIL rst_pre: q=%0d want 3", bank_q); else passed++;
    rstn = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || bank_rstn !== 1'b0 || t_out !== 4'd0) $display("FAIL rst_async: busy=%0b bank_rstn=%0b t=%0d want 0 0 0", busy, bank_rstn, t_out); else passed++;
    step();
    total++; if (bank_q !== 4'd0 || done !== 1'b0 || wrap !== 1'b0) $display("FAIL rst_clear: q=%0d done=%0b wrap=%0b want 0 0 0", bank_q, done, wrap); else passed++;
    rstn = 1'b1;
    step();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_after: busy=%0b done=%0b want 0 0", busy, done); else passed++;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
    auto_reload = 1'b0; limit = 4'd0; tick = 1'b0;
    test_reset();
    test_up_oneshot();
    test_down_reload();
    test_tick_gating();
    test_stop_collision();
    test_back_to_back();
    test_edges();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
